// File: rtl/video_clkgen_pkg.sv
// Shared types and helpers for the video clock generator: FSM state encoding,
// the default divisor width and the divisor clamp rule.
package video_clkgen_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } clkgenState_e;

  localparam int DIV_W_DEFAULT = 8;

  // Divisors below 2 cannot produce a two-phase clock, so they behave as 2.
  function automatic int unsigned clampDiv(input int unsigned div);
    return (div < 2) ? 2 : div;
  endfunction

endpackage

// File: rtl/video_clkgen_chan.sv
// One divided-clock channel: period counter plus registered outclk/clk_en.
// With VIDEO_CLKGEN_PHASE_EN defined the counter restarts at a committed phase offset.
module video_clkgen_chan
  import video_clkgen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT,
  parameter logic [DIV_W-1:0] RESET_DIV = 2
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
`ifdef VIDEO_CLKGEN_PHASE_EN
  input  logic [DIV_W-1:0] phase_i,
`endif
  output logic             outclk_o,
  output logic             clk_en_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] loadVal;
  logic             outclk_q, outclk_d;
  logic             clkEn_q, clkEn_d;
`ifdef VIDEO_CLKGEN_PHASE_EN
  logic [DIV_W-1:0] phase_q, phase_d;
`endif

  // Outputs are decoded from the next count so they line up with the registered counter.
  always_comb begin
    div_d = load_i ? div_i : div_q;
`ifdef VIDEO_CLKGEN_PHASE_EN
    phase_d = load_i ? phase_i : phase_q;
    loadVal = (phase_d > div_d - 1'b1) ? div_d - 1'b1 : phase_d;
`else
    loadVal = '0;
`endif
    if (load_i || start_i) begin
      cnt_d = loadVal;
    end else if (cnt_q >= div_q - 1'b1) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    outclk_d = (cnt_d < (div_d >> 1));
    clkEn_d  = (cnt_d == '0);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= RESET_DIV;
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      clkEn_q  <= 1'b0;
`ifdef VIDEO_CLKGEN_PHASE_EN
      phase_q  <= '0;
`endif
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      clkEn_q  <= clkEn_d;
`ifdef VIDEO_CLKGEN_PHASE_EN
      phase_q  <= phase_d;
`endif
    end
  end

  assign outclk_o = outclk_q;
  assign clk_en_o = clkEn_q;

endmodule

// File: rtl/video_clk_gen.sv
// Multi-channel video clock generator: shadow divisor write port, atomic apply,
// lock-settle FSM. Define VIDEO_CLKGEN_PHASE_EN for per-channel programmable phase.
module video_clk_gen
  import video_clkgen_pkg::*;
#(
  parameter int NUM_CLKS    = 3,
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16,
  localparam int SEL_W      = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
`ifdef VIDEO_CLKGEN_PHASE_EN
  input  logic [DIV_W-1:0]    cfg_phase,
`endif
  input  logic                cfg_apply,
  output logic                cfg_ack,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] clk_en,
  output logic                locked
);

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(clampDiv(DEFAULT_DIV));
  localparam int SETTLE_W = $clog2(LOCK_CYCLES) + 1;
  localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(LOCK_CYCLES - 1);

  clkgenState_e        state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                cfgReady_q;
  logic                ackPend_q;
  logic                cfgAck_q;
  logic [DIV_W-1:0]    shadowDiv_q [NUM_CLKS];
  logic [DIV_W-1:0]    commitDiv   [NUM_CLKS];
  logic [NUM_CLKS-1:0] wrHit;
`ifdef VIDEO_CLKGEN_PHASE_EN
  logic [DIV_W-1:0]    shadowPhase_q [NUM_CLKS];
  logic [DIV_W-1:0]    commitPhase   [NUM_CLKS];
`endif

  // A write landing on the apply edge bypasses the shadow straight into the commit.
  for (genvar gi = 0; gi < NUM_CLKS; gi++) begin : g_chan
    assign wrHit[gi] = cfg_valid && cfgReady_q && (cfg_sel == SEL_W'(gi));
    assign commitDiv[gi] = DIV_W'(clampDiv(32'(wrHit[gi] ? cfg_div : shadowDiv_q[gi])));
`ifdef VIDEO_CLKGEN_PHASE_EN
    assign commitPhase[gi] = wrHit[gi] ? cfg_phase : shadowPhase_q[gi];
`endif

    video_clkgen_chan #(
      .DIV_W     (DIV_W),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .start_i  (!cfgReady_q),
      .load_i   (cfg_apply),
      .div_i    (commitDiv[gi]),
`ifdef VIDEO_CLKGEN_PHASE_EN
      .phase_i  (commitPhase[gi]),
`endif
      .outclk_o (outclk[gi]),
      .clk_en_o (clk_en[gi])
    );
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        shadowDiv_q[i] <= RESET_DIV;
`ifdef VIDEO_CLKGEN_PHASE_EN
        shadowPhase_q[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        if (wrHit[i]) begin
          shadowDiv_q[i] <= cfg_div;
`ifdef VIDEO_CLKGEN_PHASE_EN
          shadowPhase_q[i] <= cfg_phase;
`endif
        end
      end
    end
  end

  // Apply always restarts the settle interval, whichever state the FSM is in.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (cfg_apply) begin
      state_d  = SETTLE;
      settle_d = '0;
    end else if (state_q == SETTLE) begin
      if (settle_q == LAST_SETTLE) begin
        state_d = LOCKED;
      end else begin
        settle_d = settle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      settle_q   <= '0;
      cfgReady_q <= 1'b0;
      ackPend_q  <= 1'b0;
      cfgAck_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      cfgReady_q <= 1'b1;
      ackPend_q  <= cfg_apply;
      cfgAck_q   <= ackPend_q;
    end
  end

  assign cfg_ready = cfgReady_q;
  assign cfg_ack   = cfgAck_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_video_clk_gen.sv
// Directed self-checking bench for video_clk_gen (3 channels, 8-bit divisors, lock after 16 edges).
module tb_video_clk_gen;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic       cfgValid = 1'b0;
  logic       cfgApply = 1'b0;
  logic [1:0] cfgSel   = '0;
  logic [7:0] cfgDiv   = '0;
`ifdef VIDEO_CLKGEN_PHASE_EN
  logic [7:0] cfgPhase = '0;
`endif
  logic       cfgReady;
  logic       cfgAck;
  logic [2:0] outclk;
  logic [2:0] clkEn;
  logic       locked;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 refclk = ~refclk;

  video_clk_gen #(
    .NUM_CLKS    (3),
    .DIV_W       (8),
    .DEFAULT_DIV (2),
    .LOCK_CYCLES (16)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfgValid),
    .cfg_ready (cfgReady),
    .cfg_sel   (cfgSel),
    .cfg_div   (cfgDiv),
`ifdef VIDEO_CLKGEN_PHASE_EN
    .cfg_phase (cfgPhase),
`endif
    .cfg_apply (cfgApply),
    .cfg_ack   (cfgAck),
    .outclk    (outclk),
    .clk_en    (clkEn),
    .locked    (locked)
  );

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  // Expected outputs m edges after a realignment (c=0 at m=0) for divisors d0..d2.
  function automatic logic [2:0] expOut(int m, int d0, int d1, int d2);
    int d [3];
    logic [2:0] r;
    d = '{d0, d1, d2};
    for (int i = 0; i < 3; i++) r[i] = ((m % d[i]) < (d[i] / 2));
    return r;
  endfunction

  function automatic logic [2:0] expEn(int m, int d0, int d1, int d2);
    int d [3];
    logic [2:0] r;
    d = '{d0, d1, d2};
    for (int i = 0; i < 3; i++) r[i] = ((m % d[i]) == 0);
    return r;
  endfunction

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick;
    tick;
    testsRun++;
    if ({outclk, clkEn, locked, cfgAck, cfgReady} !== 9'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset outputs got outclk=%b clk_en=%b locked=%b ack=%b ready=%b exp all 0",
               outclk, clkEn, locked, cfgAck, cfgReady);
    end
  endtask

  task automatic test_defaults;
    rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick;
      testsRun++;
      if (outclk !== expOut(n - 1, 2, 2, 2) || clkEn !== expEn(n - 1, 2, 2, 2)) begin
        testsFailed++;
        $display("[TB] FAIL defaults edge %0d got outclk=%b clk_en=%b exp %b/%b",
                 n, outclk, clkEn, expOut(n - 1, 2, 2, 2), expEn(n - 1, 2, 2, 2));
      end
      testsRun++;
      if (locked !== (n >= 16) || cfgReady !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL defaults lock edge %0d got locked=%b ready=%b exp locked=%b ready=1",
                 n, locked, cfgReady, (n >= 16));
      end
    end
  endtask

  task automatic test_write_apply;
    cfgValid = 1'b1; cfgSel = 2'd2; cfgDiv = 8'd5;
    tick;
    cfgValid = 1'b0;
    testsRun++;
    if (outclk !== expOut(17, 2, 2, 2) || clkEn !== expEn(17, 2, 2, 2) || locked !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL write_no_commit got outclk=%b clk_en=%b locked=%b exp %b/%b/1",
               outclk, clkEn, locked, expOut(17, 2, 2, 2), expEn(17, 2, 2, 2));
    end
    for (int m = 0; m <= 20; m++) begin
      cfgApply = (m == 0);
      tick;
      testsRun++;
      if (outclk !== expOut(m, 2, 2, 5) || clkEn !== expEn(m, 2, 2, 5)) begin
        testsFailed++;
        $display("[TB] FAIL div5 m=%0d got outclk=%b clk_en=%b exp %b/%b",
                 m, outclk, clkEn, expOut(m, 2, 2, 5), expEn(m, 2, 2, 5));
      end
      testsRun++;
      if (cfgAck !== (m == 1) || locked !== (m >= 16)) begin
        testsFailed++;
        $display("[TB] FAIL div5_ctl m=%0d got ack=%b locked=%b exp ack=%b locked=%b",
                 m, cfgAck, locked, (m == 1), (m >= 16));
      end
    end
    cfgApply = 1'b0;
  endtask

  task automatic test_bypass;
    for (int m = 0; m <= 9; m++) begin
      cfgValid = (m == 0); cfgApply = (m == 0); cfgSel = 2'd0; cfgDiv = 8'd4;
      tick;
      testsRun++;
      if (outclk !== expOut(m, 4, 2, 5) || clkEn !== expEn(m, 4, 2, 5) || cfgAck !== (m == 1)) begin
        testsFailed++;
        $display("[TB] FAIL bypass m=%0d got outclk=%b clk_en=%b ack=%b exp %b/%b/%b",
                 m, outclk, clkEn, cfgAck, expOut(m, 4, 2, 5), expEn(m, 4, 2, 5), (m == 1));
      end
    end
    cfgValid = 1'b0; cfgApply = 1'b0;
  endtask

  task automatic test_clamp_and_sel;
    cfgValid = 1'b1; cfgSel = 2'd1; cfgDiv = 8'd0;
    tick;
    cfgValid = 1'b0;
    for (int m = 0; m <= 5; m++) begin
      cfgApply = (m == 0);
      tick;
      testsRun++;
      if (outclk !== expOut(m, 4, 2, 5) || clkEn !== expEn(m, 4, 2, 5)) begin
        testsFailed++;
        $display("[TB] FAIL clamp0 m=%0d got outclk=%b clk_en=%b exp %b/%b",
                 m, outclk, clkEn, expOut(m, 4, 2, 5), expEn(m, 4, 2, 5));
      end
    end
    cfgApply = 1'b0;
    cfgValid = 1'b1; cfgSel = 2'd1; cfgDiv = 8'd1;
    tick;
    cfgSel = 2'd3; cfgDiv = 8'd7;
    tick;
    cfgValid = 1'b0;
    for (int m = 0; m <= 7; m++) begin
      cfgApply = (m == 0);
      tick;
      testsRun++;
      if (outclk !== expOut(m, 4, 2, 5) || clkEn !== expEn(m, 4, 2, 5)) begin
        testsFailed++;
        $display("[TB] FAIL clamp1_sel3 m=%0d got outclk=%b clk_en=%b exp %b/%b",
                 m, outclk, clkEn, expOut(m, 4, 2, 5), expEn(m, 4, 2, 5));
      end
    end
    cfgApply = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lastApply = 0;
    logic prevApply = 1'b0;
    logic applyNow;
    for (int m = 0; m <= 34; m++) begin
      applyNow = (m == 0) || (m == 10) || (m == 15) || (m == 16);
      cfgApply = applyNow;
      tick;
      if (applyNow) lastApply = m;
      testsRun++;
      if (outclk !== expOut(m - lastApply, 4, 2, 5) || clkEn !== expEn(m - lastApply, 4, 2, 5)) begin
        testsFailed++;
        $display("[TB] FAIL b2b m=%0d got outclk=%b clk_en=%b exp %b/%b", m, outclk, clkEn,
                 expOut(m - lastApply, 4, 2, 5), expEn(m - lastApply, 4, 2, 5));
      end
      testsRun++;
      if (cfgAck !== prevApply || locked !== ((m - lastApply) >= 16)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_ctl m=%0d got ack=%b locked=%b exp ack=%b locked=%b",
                 m, cfgAck, locked, prevApply, ((m - lastApply) >= 16));
      end
      prevApply = applyNow;
    end
    cfgApply = 1'b0;
  endtask

  task automatic test_async_reset;
    tick;
    #3 rst_n = 1'b0;
    #1;
    testsRun++;
    if ({outclk, clkEn, locked, cfgAck, cfgReady} !== 9'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset got outclk=%b clk_en=%b locked=%b ack=%b ready=%b exp all 0",
               outclk, clkEn, locked, cfgAck, cfgReady);
    end
    tick;
    tick;
    rst_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick;
      testsRun++;
      if (outclk !== expOut(n - 1, 2, 2, 2) || clkEn !== expEn(n - 1, 2, 2, 2) || locked !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL post_reset edge %0d got outclk=%b clk_en=%b locked=%b exp %b/%b/0",
                 n, outclk, clkEn, locked, expOut(n - 1, 2, 2, 2), expEn(n - 1, 2, 2, 2));
      end
    end
    for (int m = 0; m <= 5; m++) begin
      cfgApply = (m == 0);
      tick;
      testsRun++;
      if (outclk !== expOut(m, 2, 2, 2) || clkEn !== expEn(m, 2, 2, 2)) begin
        testsFailed++;
        $display("[TB] FAIL shadow_lost m=%0d got outclk=%b clk_en=%b exp %b/%b",
                 m, outclk, clkEn, expOut(m, 2, 2, 2), expEn(m, 2, 2, 2));
      end
    end
    cfgApply = 1'b0;
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_write_apply;
    test_bypass;
    test_clamp_and_sel;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/video_clk_gen.md
# video_clk_gen

Parametrised multi-channel clock generator for the video subsystem: derives NUM_CLKS divided clocks (50 %-style duty) and matching one-cycle clock-enable strobes from a single reference clock. Divisors are programmable at run time through a shadow-register write port and committed atomically with an apply pulse, which realigns all channels and re-runs a lock-settle interval. Sits between the board reference clock and the pixel/LCD timing blocks, which consume either the divided clocks or the enables.

## Interface
Parameters:
- NUM_CLKS, 3, number of output channels (1..16)
- DIV_W, 8, divisor / counter width in bits
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (clamped to >= 2)
- LOCK_CYCLES, 16, refclk cycles of stable operation before locked asserts (>= 1)

Ports:
- refclk  in  1  reference clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  shadow-divisor write request
- cfg_ready  out  1  write port can accept
- cfg_sel  in  $clog2(NUM_CLKS) (min 1)  target channel
- cfg_div  in  DIV_W  new divisor
- cfg_apply  in  1  commit all shadow divisors (single-cycle pulse)
- cfg_ack  out  1  one-cycle pulse acknowledging a commit
- outclk  out  NUM_CLKS  divided clocks, bit i = channel i
- clk_en  out  NUM_CLKS  one-cycle enable strobes, bit i = channel i
- locked  out  1  all channels stable at committed divisors

## Operation
- Each channel: active divisor D (clamped: values 0/1 act as 2), counter c counting 0..D-1 then wrapping to 0.
- clk_en[i] high for exactly the cycle in which c==0; outclk[i] high while c < D>>1, low otherwise (odd D: high floor(D/2), low ceil(D/2)).
- Write port: cfg_ready=1 whenever out of reset. cfg_valid&cfg_ready writes cfg_div into shadow[cfg_sel]; cfg_sel >= NUM_CLKS is ignored (no shadow change). Active divisors untouched by writes.
- cfg_apply: at that edge all active divisors <= shadows, all counters <= 0 (phase-aligned), settle counter cleared, locked <= 0, FSM -> SETTLE; cfg_ack high the following cycle.
- FSM states: SETTLE (count settle cycles), LOCKED. SETTLE -> LOCKED when settle count reaches LOCK_CYCLES-1; LOCKED -> SETTLE only on cfg_apply; cfg_apply in SETTLE restarts the count.
- Simultaneous cfg_valid write and cfg_apply: the write is included in the committed set (bypass into active divisor).
- Back-to-back cfg_apply: each commits; cfg_ack pulses for each.

## Timing
- Reset (rst_n low, asynchronous): outclk=0, clk_en=0, locked=0, cfg_ack=0, cfg_ready=0, counters=0, active and shadow divisors = clamped DEFAULT_DIV, FSM=SETTLE.
- First rising edge after release: cfg_ready=1; counters start; clk_en[i] high in first cycle after release (c==0).
- locked rises on the LOCK_CYCLES-th rising edge after reset release or after the apply edge; stays high until next apply or reset.
- Apply latency: new divisor visible from edge k (apply sampled); first clk_en of new period at cycle k; cfg_ack at k+1.
- All outputs registered; no combinational input-to-output path except none.
- Reset mid-settle or mid-period: immediate return to reset values; shadow writes lost.

## Configuration
- VIDEO_CLKGEN_PHASE_EN defined: adds input cfg_phase (DIV_W) and per-channel phase shadows written with cfg_div; on apply and reset, counter i loads min(phase_i, D_i-1) instead of 0 (reset phase 0), giving programmable relative skew.
- Undefined: no cfg_phase port, no phase storage; counters always load 0.

## Structure
- Package video_clkgen_pkg: FSM state enum (SETTLE, LOCKED), DIV_W default constant, divisor clamp function.
- Sub-module video_clkgen_chan: one channel (counter, outclk/clk_en registers, optional phase load); top instantiates NUM_CLKS of them plus shadow regs and FSM.

## Test plan
- Reset release, defaults (DIV 2, LOCK 16): all outclk toggle every cycle, clk_en every 2 cycles, locked rises on edge 16.
- Write ch2 div=5, apply: ch2 outclk high 2 / low 3 cycles, clk_en every 5; locked low at apply, high 16 edges later; cfg_ack one cycle after apply.
- cfg_valid (ch0 div=4) same cycle as cfg_apply: ch0 runs at 4 immediately; other channels unchanged but realigned to c=0.
- cfg_div=0 and 1 on ch1, apply: ch1 behaves as D=2; cfg_sel=3 with NUM_CLKS=3: no effect.
- Apply at settle count 10, then again at 5: locked stays low until 16 edges after the last apply; two cfg_ack pulses.
- With VIDEO_CLKGEN_PHASE_EN: ch0 D=4 phase 0, ch1 D=4 phase 2, apply: ch1 clk_en leads ch0 by 2 cycles; reset mid-operation clears all outputs asynchronously.
